open_border_ctrl_unit: RTL and testbench

Control unit that drives the open-border 7×7 mask and row-buffer datapath. It accepts a raster-order pixel stream from upstream over a valid/ready handshake and forwards each pixel to the row buffers as `data_cu2bufcf` / `ctrl2buf_valid`. It tracks the window-centre position and generates the top, bottom, left and right mirror selects for every shift. At end of frame it flushes the buffers so that exactly one window per image pixel reaches the filter.

---
 rtl/open_border_ctrl_unit_pkg.sv | 40 ++++
 rtl/open_border_ctrl_unit_if.sv | 36 +++
 rtl/open_border_ctrl_unit_raster_counter.sv | 49 ++++
 rtl/open_border_ctrl_unit.sv | 163 ++++++++++++++++
 tb/tb_open_border_ctrl_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/open_border_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// open_border_pkg
// Shared definitions for the open-border 7x7 mask control unit:
//   HALF       - mask half-width (centre offset in rows and columns)
//   state_e    - control FSM states
//   sel_e      - bottom/right mirror select encodings
//   lat_f()    - shifts between an incoming pixel and the window centre
//   edge_sel() - distance-to-far-edge decode into a sel_e
// -----------------------------------------------------------------------------
package open_border_pkg;

  localparam int HALF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_NORM = 2'd0,
    SEL_D2   = 2'd1,
    SEL_D1   = 2'd2,
    SEL_D0   = 2'd3
  } sel_e;

  function automatic int lat_f(input int row_width);
    return HALF * row_width + HALF;
  endfunction

  // Mirror select for the far (bottom/right) border: how close pos is to size-1.
  function automatic sel_e edge_sel(input int pos, input int size);
    if (pos == size - 1)      return SEL_D0;
    else if (pos == size - 2) return SEL_D1;
    else if (pos == size - 3) return SEL_D2;
    else                      return SEL_NORM;
  endfunction

endpackage

// File: rtl/open_border_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// open_border_ctrl_unit_if
// Pixel-stream and row-buffer/filter signals of the control unit.
//   master : upstream/observer side (drives pix_in, pix_in_valid)
//   slave  : control unit side (drives ready, buffer shift and selects)
// Signals: pix_in, pix_in_valid, pix_in_ready, data_cu2bufcf, ctrl2buf_valid,
//          sel_top_row, sel_btm_row, sel_left_col, sel_right_col, win_valid,
//          frame_done.
// -----------------------------------------------------------------------------
interface open_border_ctrl_unit_if #(
  parameter int PIX_BIT = 8
);
  logic [PIX_BIT-1:0] pix_in;
  logic               pix_in_valid;
  logic               pix_in_ready;
  logic [PIX_BIT-1:0] data_cu2bufcf;
  logic               ctrl2buf_valid;
  logic               sel_top_row;
  logic [1:0]         sel_btm_row;
  logic               sel_left_col;
  logic [1:0]         sel_right_col;
  logic               win_valid;
  logic               frame_done;

  modport master (
    output pix_in, pix_in_valid,
    input  pix_in_ready, data_cu2bufcf, ctrl2buf_valid, sel_top_row,
           sel_btm_row, sel_left_col, sel_right_col, win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_in_valid,
    output pix_in_ready, data_cu2bufcf, ctrl2buf_valid, sel_top_row,
           sel_btm_row, sel_left_col, sel_right_col, win_valid, frame_done
  );
endinterface

// File: rtl/open_border_ctrl_unit_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Raster-order (row, col) position counter; col wraps at ROW_WIDTH-1 and
// carries into row, row wraps at COL_HEIGHT-1.
// Ports: clk, reset (async active-low), en (advance), clr (sync clear, wins
//        over en), row, col (current position), last (at final pixel).
// -----------------------------------------------------------------------------
module raster_counter #(
  parameter int ROW_WIDTH  = 100,
  parameter int COL_HEIGHT = 100,
  localparam int CBW = $clog2(ROW_WIDTH),
  localparam int RBW = $clog2(COL_HEIGHT)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           clr,
  output logic [RBW-1:0] row,
  output logic [CBW-1:0] col,
  output logic           last
);
  logic [RBW-1:0] row_q;
  logic [CBW-1:0] col_q;
  logic           col_end, row_end;

  assign col_end = (col_q == CBW'(ROW_WIDTH - 1));
  assign row_end = (row_q == RBW'(COL_HEIGHT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + RBW'(1);
      end else begin
        col_q <= col_q + CBW'(1);
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = row_end & col_end;
endmodule

// File: rtl/open_border_ctrl_unit.sv
// -----------------------------------------------------------------------------
// open_border_ctrl_unit
// Control unit for the open-border 7x7 mask / row-buffer datapath. Forwards
// accepted pixels into the row buffers, tracks the window centre, generates
// mirror selects and flushes the buffers at end of frame so that exactly one
// window per image pixel reaches the filter.
// Ports: clk, reset (async active-low), bus (open_border_ctrl_unit_if.slave).
// Optional macro OPEN_BORDER_CTRL_STATS_EN adds frame_cnt[15:0] (completed
// frames, wrapping) and stall_cnt[31:0] (FILL/RUN cycles without an accept,
// cleared at frame start, saturating).
//
// state | meaning
// IDLE  | waiting for first pixel of a frame
// FILL  | priming buffers, shifts carry no valid window
// RUN   | every accept shifts out a valid window
// FLUSH | input blocked, zero pixels shifted to drain remaining windows
// -----------------------------------------------------------------------------
module open_border_ctrl_unit
  import open_border_pkg::*;
#(
  parameter int ROW_WIDTH  = 100,
  parameter int COL_HEIGHT = 100,
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7
) (
  input logic clk,
  input logic reset,
  open_border_ctrl_unit_if.slave bus
`ifdef OPEN_BORDER_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [31:0] stall_cnt
`endif
);
  localparam int HW  = MASK_WIDTH / 2;
  localparam int LAT = lat_f(ROW_WIDTH);
  localparam int CBW = $clog2(ROW_WIDTH);
  localparam int RBW = $clog2(COL_HEIGHT);
  // Position of accept number LAT (0-based index LAT-1): last FILL accept.
  localparam int FILL_END_ROW = (LAT - 1) / ROW_WIDTH;
  localparam int FILL_END_COL = (LAT - 1) % ROW_WIDTH;

  state_e             state_q, state_d;
  logic               accept;
  logic               shift_d, win_d, done_d;
  logic [PIX_BIT-1:0] data_d;
  logic [RBW-1:0]     in_row, c_row;
  logic [CBW-1:0]     in_col, c_col;
  logic               in_last, c_last;

  logic [PIX_BIT-1:0] data_q;
  logic               shift_q, win_q, done_q, top_q, left_q;
  logic [1:0]         btm_q, right_q;

  assign bus.pix_in_ready = (state_q != FLUSH);
  assign accept           = bus.pix_in_valid & bus.pix_in_ready;

  raster_counter #(.ROW_WIDTH(ROW_WIDTH), .COL_HEIGHT(COL_HEIGHT)) u_in_pos (
    .clk(clk), .reset(reset), .en(accept), .clr(done_d),
    .row(in_row), .col(in_col), .last(in_last)
  );

  // Centre position advances only on window-producing shifts.
  raster_counter #(.ROW_WIDTH(ROW_WIDTH), .COL_HEIGHT(COL_HEIGHT)) u_ctr_pos (
    .clk(clk), .reset(reset), .en(win_d), .clr(done_d),
    .row(c_row), .col(c_col), .last(c_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    shift_d = 1'b0;
    win_d   = 1'b0;
    done_d  = 1'b0;
    data_d  = '0;
    unique case (state_q)
      IDLE: if (accept) begin
        shift_d = 1'b1;
        data_d  = bus.pix_in;
        state_d = FILL;
      end
      FILL: if (accept) begin
        shift_d = 1'b1;
        data_d  = bus.pix_in;
        if (in_row == RBW'(FILL_END_ROW) && in_col == CBW'(FILL_END_COL))
          state_d = RUN;
      end
      RUN: if (accept) begin
        shift_d = 1'b1;
        win_d   = 1'b1;
        data_d  = bus.pix_in;
        if (in_last) state_d = FLUSH;
      end
      FLUSH: begin
        shift_d = 1'b1;
        win_d   = 1'b1;
        // The final window is the one centred on the last pixel.
        if (c_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      shift_q <= 1'b0;
      win_q   <= 1'b0;
      done_q  <= 1'b0;
      top_q   <= 1'b0;
      left_q  <= 1'b0;
      btm_q   <= SEL_NORM;
      right_q <= SEL_NORM;
    end else begin
      data_q  <= data_d;
      shift_q <= shift_d;
      win_q   <= win_d;
      done_q  <= done_d;
      top_q   <= win_d & (c_row < RBW'(HW));
      left_q  <= win_d & (c_col < CBW'(HW));
      btm_q   <= win_d ? edge_sel(int'(c_row), COL_HEIGHT) : SEL_NORM;
      right_q <= win_d ? edge_sel(int'(c_col), ROW_WIDTH) : SEL_NORM;
    end
  end

  assign bus.data_cu2bufcf  = data_q;
  assign bus.ctrl2buf_valid = shift_q;
  assign bus.win_valid      = win_q;
  assign bus.frame_done     = done_q;
  assign bus.sel_top_row    = top_q;
  assign bus.sel_left_col   = left_q;
  assign bus.sel_btm_row    = btm_q;
  assign bus.sel_right_col  = right_q;

`ifdef OPEN_BORDER_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = ((state_q == FILL) || (state_q == RUN)) && !accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q == IDLE && accept)       stall_cnt_q <= '0;
      else if (stall && ~&stall_cnt_q)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_open_border_ctrl_unit.sv
module tb_open_border_ctrl_unit;
  localparam int RW  = 8;
  localparam int CH  = 8;
  localparam int N   = RW * CH;
  localparam int LAT = 3 * RW + 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  open_border_ctrl_unit_if #(.PIX_BIT(8)) bus();
`ifdef OPEN_BORDER_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [31:0] stall_cnt;
`endif

  open_border_ctrl_unit #(
    .ROW_WIDTH(RW), .COL_HEIGHT(CH), .PIX_BIT(8), .MASK_WIDTH(7)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef OPEN_BORDER_CTRL_STATS_EN
    , .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: the pixels accepted in this frame, and counts of
  // what has been observed so far.
  logic [7:0] pq[$];
  int acc_cnt = 0, shift_cnt = 0, win_cnt = 0, ready_low = 0;
  int gap_run = 0, last_gap = 0, since_done = 0;
  int frames_seen = 0, frame_starts = 0, start_target = 0, gap_left = 0;
  bit prev_acc = 0, b2b_mode = 0, b2b_watch = 0, rnd_mode = 0, gap_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    acc_cnt = 0; shift_cnt = 0; win_cnt = 0; ready_low = 0;
    gap_run = 0; since_done = 0; prev_acc = 0; b2b_watch = 0;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_outputs"}, {bus.data_cu2bufcf, bus.ctrl2buf_valid, bus.sel_top_row,
        bus.sel_btm_row, bus.sel_left_col, bus.sel_right_col, bus.win_valid,
        bus.frame_done}, 32'd0);
    chk({tag, "_ready"}, bus.pix_in_ready, 1);
  endtask

  // Shift k of a frame carries accepted pixel k (zero once flushing); shifts
  // from LAT onward carry the window centred on raster index k-LAT.
  task automatic check_cycle();
    bit ev, ew, ed;
    int k, idx, r, c, e_top, e_btm, e_left, e_right, e_data;
    if (!bus.pix_in_ready) ready_low++;
    ev = prev_acc || (acc_cnt == N && shift_cnt >= N && shift_cnt < N + LAT);
    chk("shift_strobe", bus.ctrl2buf_valid, ev);
    if (bus.ctrl2buf_valid) begin
      k = shift_cnt;
      e_data = (k < acc_cnt) ? int'(pq[k]) : 0;
      ew = (k >= LAT);
      e_top = 0; e_btm = 0; e_left = 0; e_right = 0; ed = 0; idx = 0;
      if (ew) begin
        idx = k - LAT;
        r = idx / RW;
        c = idx % RW;
        e_top   = (r < 3) ? 1 : 0;
        e_left  = (c < 3) ? 1 : 0;
        e_btm   = (r >= CH - 3) ? r - (CH - 4) : 0;
        e_right = (c >= RW - 3) ? c - (RW - 4) : 0;
        ed = (idx == N - 1);
      end
      chk("data", bus.data_cu2bufcf, e_data);
      chk("win_valid", bus.win_valid, ew);
      chk("sel_top_row", bus.sel_top_row, e_top);
      chk("sel_btm_row", bus.sel_btm_row, e_btm);
      chk("sel_left_col", bus.sel_left_col, e_left);
      chk("sel_right_col", bus.sel_right_col, e_right);
      chk("frame_done", bus.frame_done, ed);
      if (b2b_watch) begin
        chk("b2b_first_shift_delay", since_done, 1);
        b2b_watch = 0;
      end
      if (gap_run > 0) begin
        last_gap = gap_run;
        gap_run = 0;
      end
      shift_cnt++;
      if (ew) win_cnt++;
      if (ed) begin
        chk("shifts_per_frame", shift_cnt, N + LAT);
        chk("windows_per_frame", win_cnt, N);
        chk("ready_low_cycles", ready_low, LAT);
        frames_seen++;
        b2b_watch = b2b_mode && (frame_starts < start_target);
        pq.delete();
        acc_cnt = 0; shift_cnt = 0; win_cnt = 0; ready_low = 0;
        since_done = 0;
      end
    end else begin
      chk("idle_outputs", {bus.win_valid, bus.frame_done, bus.sel_top_row,
          bus.sel_btm_row, bus.sel_left_col, bus.sel_right_col}, 32'd0);
      if (shift_cnt > 0 && shift_cnt < N) gap_run++;
    end
    since_done++;
  endtask

  task automatic step();
    bit v, acc;
    @(negedge clk);
    check_cycle();
    v = (acc_cnt > 0) ? (acc_cnt < N) : (frame_starts < start_target);
    if (v && gap_mode && acc_cnt == 40 && gap_left > 0) begin
      v = 0;
      gap_left--;
    end
    if (v && rnd_mode && $urandom_range(0, 3) == 0) v = 0;
    bus.pix_in_valid = v;
    bus.pix_in = 8'($urandom);
    acc = v && bus.pix_in_ready;
    if (acc) begin
      if (acc_cnt == 0) frame_starts++;
      pq.push_back(bus.pix_in);
      acc_cnt++;
    end
    prev_acc = acc;
  endtask

  task automatic run_frames(input int nf, input bit b2b, input bit gap, input bit rnd);
    int target = frames_seen + nf;
    int b = 0;
    start_target = frame_starts + nf;
    b2b_mode = b2b; gap_mode = gap; rnd_mode = rnd; gap_left = 5;
    while (frames_seen < target && b < 2000) begin
      step();
      b++;
    end
    chk("frames_completed", frames_seen, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bus.pix_in_valid = 1'b0;
    bus.pix_in = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rst_check("reset");
`ifdef OPEN_BORDER_CTRL_STATS_EN
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
`endif
    reset = 1'b1;

    // Continuous frame, then one with a 5-cycle gap in RUN, then random gaps.
    run_frames(1, 0, 0, 0);
    run_frames(1, 0, 1, 0);
    chk("stall_gap_len", last_gap, 5);
`ifdef OPEN_BORDER_CTRL_STATS_EN
    chk("stall_cnt_gap_frame", stall_cnt, 5);
`endif
    run_frames(1, 0, 0, 1);

    // Abort a frame with reset part-way through FLUSH.
    start_target = frame_starts + 1;
    b2b_mode = 0; gap_mode = 0; rnd_mode = 0;
    b = 0;
    while (ready_low < 10 && b < 500) begin
      step();
      b++;
    end
    chk("abort_reached_flush", (ready_low >= 10), 1);
    #2 reset = 1'b0;
    bus.pix_in_valid = 1'b0;
    @(negedge clk);
    rst_check("flush_abort");
    reset = 1'b1;
    model_reset();
    run_frames(1, 0, 0, 0);

    // Fresh reset, then two frames back-to-back.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rst_check("reset2");
    reset = 1'b1;
    model_reset();
    run_frames(2, 1, 0, 0);
`ifdef OPEN_BORDER_CTRL_STATS_EN
    chk("frame_cnt_b2b", frame_cnt, 2);
    chk("stall_cnt_b2b", stall_cnt, 0);
`endif
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
